// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the fetch/load-store memory arbiter
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of data wins over a waiting fetch
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q;

  // With LIMIT == 0 the count never leaves 0, so at_limit is permanently
  // high and the fetch port always wins a tie.
  assign at_limit = (cnt_q == LIM);

  // Clear has priority; increments stop once the limit is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_limit) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - one-outstanding arbiter sharing a memory between fetch and LSU
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic [ADDRESS_WIDTH-1:0]  i_addr,
  output logic                      i_gnt,
  output logic                      i_rvalid,
  output logic [DATA_WIDTH-1:0]     i_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [DATA_WIDTH/8-1:0]   d_be,
  input  logic [ADDRESS_WIDTH-1:0]  d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      m_req,
  output logic                      m_we,
  output logic [DATA_WIDTH/8-1:0]   m_be,
  output logic [ADDRESS_WIDTH-1:0]  m_addr,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  input  logic                      m_rvalid,
  input  logic [DATA_WIDTH-1:0]     m_rdata
);

  localparam int BE_W = DATA_WIDTH / 8;

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;

  logic                     m_req_d, m_we_d;
  logic [BE_W-1:0]          m_be_d;
  logic [ADDRESS_WIDTH-1:0] m_addr_d;
  logic [DATA_WIDTH-1:0]    m_wdata_d;
  logic                     i_gnt_d, d_gnt_d, i_rvalid_d, d_rvalid_d;
  logic [DATA_WIDTH-1:0]    i_rdata_d, d_rdata_d;
  logic                     win_i;
  logic                     starve_inc, starve_clr, starve_at_limit;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (starve_at_limit)
  );

  // Next state, command latch and response routing; every output is the
  // registered copy of a *_d value so nothing reaches a port combinationally.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    m_we_d     = m_we;
    m_be_d     = m_be;
    m_addr_d   = m_addr;
    m_wdata_d  = m_wdata;
    i_rdata_d  = i_rdata;
    d_rdata_d  = d_rdata;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    win_i      = i_req && (!d_req || starve_at_limit);

    unique case (state_q)
      IDLE, RESP: begin
        if (i_req || d_req) begin
          state_d    = ISSUE;
          starve_inc = i_req && d_req && !win_i;
          starve_clr = win_i || !i_req;
          if (win_i) begin
            owner_d   = OWN_I;
            m_we_d    = 1'b0;
            m_be_d    = '1;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
          end else begin
            owner_d   = OWN_D;
            m_we_d    = d_we;
            m_be_d    = d_be;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (m_rvalid) begin
          state_d = RESP;
          if (owner_q == OWN_I) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = m_rdata;
          end else begin
            d_rvalid_d = 1'b1;
            // A write ack leaves the last read data in place.
            if (!m_we) begin
              d_rdata_d = m_rdata;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    m_req_d = (state_d == ISSUE);
    i_gnt_d = m_req_d && (owner_d == OWN_I);
    d_gnt_d = m_req_d && (owner_d == OWN_D);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      m_req    <= m_req_d;
      m_we     <= m_we_d;
      m_be     <= m_be_d;
      m_addr   <= m_addr_d;
      m_wdata  <= m_wdata_d;
      i_gnt    <= i_gnt_d;
      d_gnt    <= d_gnt_d;
      i_rvalid <= i_rvalid_d;
      d_rvalid <= d_rvalid_d;
      i_rdata  <= i_rdata_d;
      d_rdata  <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int lat       = 1;

  logic [31:0] mem     [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .STARVE_LIMIT  (SL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          l;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a[31:2]]     = v;
    ref_mem[a[31:2]] = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Fixed-latency memory: answers each m_req exactly lat cycles later.
  initial begin : mem_model
    int          cnt;
    logic [31:0] ca, cwd;
    logic [3:0]  cbe;
    logic        cwe;
    cnt = 0; ca = '0; cwd = '0; cbe = '0; cwe = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    forever begin
      @(negedge clk);
      m_rvalid = 1'b0;
      m_rdata  = $urandom;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          m_rvalid = 1'b1;
          if (cwe) mem[ca[31:2]] = merge(mem_rd(ca), cbe, cwd);
          else     m_rdata = mem_rd(ca);
        end
      end
      if (m_req === 1'b1) begin
        cnt = lat; ca = m_addr; cwe = m_we; cbe = m_be; cwd = m_wdata;
      end
    end
  end

  // One isolated transaction from IDLE; cycle 0 is the cycle the request appears.
  task automatic do_txn(input vec_t v, input int idx);
    int          gcyc, rcyc, rcnt, other;
    logic [31:0] rd;
    bit          stable, issue_ok;
    gcyc = -1; rcyc = -1; rcnt = 0; other = 0; rd = '0; stable = 1; issue_ok = 0;
    lat = v.l;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1; i_addr = v.addr;
    end
    for (int k = 0; k < v.l + 6; k++) begin
      @(negedge clk);
      if ((v.is_d ? d_gnt : i_gnt) === 1'b1) begin
        if (gcyc < 0) gcyc = k;
        issue_ok = (m_req === 1'b1) && (m_addr === v.addr) && (m_we === v.we) &&
                   (!v.is_d || m_be === v.be);
        i_req = 0; d_req = 0;
      end
      if ((v.is_d ? d_rvalid : i_rvalid) === 1'b1) begin
        rcyc = k; rcnt++;
        rd = v.is_d ? d_rdata : i_rdata;
      end
      if ((v.is_d ? (i_gnt | i_rvalid) : (d_gnt | d_rvalid)) !== 1'b0) other++;
      if (gcyc >= 0 && rcyc < 0 && m_addr !== v.addr) stable = 0;
    end
    chk($sformatf("v%0d_gnt_cycle", idx), gcyc, 1);
    chk($sformatf("v%0d_issue_fields", idx), 32'(issue_ok), 1);
    chk($sformatf("v%0d_rvalid_cycle", idx), rcyc, 2 + v.l);
    chk($sformatf("v%0d_rvalid_count", idx), rcnt, 1);
    chk($sformatf("v%0d_rdata", idx), rd, v.exp_rd);
    chk($sformatf("v%0d_other_port_quiet", idx), other, 0);
    chk($sformatf("v%0d_m_addr_stable", idx), 32'(stable), 1);
  endtask

  initial begin : main
    vec_t        vecs [5];
    int          gd, gi, nd, nd_at, r1, r2, ng, rv, rs, ngr;
    bit          gi_seen, exp_i;
    logic [31:0] d1, d2, exp_drd;
    mem_cmd_t    t;
    mem_cmd_t    dq [$];
    logic [31:0] iq [$];

    vecs[0] = '{is_d: 0, we: 0, be: 4'h0, addr: 32'h40,  wdata: 32'h0,        l: 1, exp_rd: 32'h00500093};
    vecs[1] = '{is_d: 1, we: 0, be: 4'hF, addr: 32'h100, wdata: 32'h0,        l: 1, exp_rd: 32'h11223344};
    vecs[2] = '{is_d: 1, we: 1, be: 4'h3, addr: 32'h200, wdata: 32'hDEADBEEF, l: 2, exp_rd: 32'h11223344};
    vecs[3] = '{is_d: 1, we: 0, be: 4'hF, addr: 32'h200, wdata: 32'h0,        l: 2, exp_rd: 32'hCAFEBEEF};
    vecs[4] = '{is_d: 0, we: 0, be: 4'h0, addr: 32'h44,  wdata: 32'h0,        l: 4, exp_rd: 32'h00A00113};

    preload(32'h40,  32'h00500093);
    preload(32'h44,  32'h00A00113);
    preload(32'h100, 32'h11223344);
    preload(32'h200, 32'hCAFEF00D);
    preload(32'h0,   32'h00000013);
    preload(32'h4,   32'h00100093);

    rst = 1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_strobes", 32'({i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, m_be}), 0);
    chk("reset_i_rdata", i_rdata, 0);
    chk("reset_d_rdata", d_rdata, 0);
    chk("reset_m_addr", m_addr, 0);
    chk("reset_m_wdata", m_wdata, 0);
    chk("reset_state", 32'(dut.state_q), 32'(IDLE));

    for (int i = 0; i < 5; i++) do_txn(vecs[i], i);

    // Reset while WAITing; the memory answers in the cycle right after.
    lat = 2;
    @(posedge clk); #1; i_req = 1; i_addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_gnt", 32'(i_gnt), 1);
    i_req = 0;
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    rv = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if ((i_rvalid | d_rvalid) !== 1'b0) rv++;
      if (k == 0) begin
        chk("rstw_late_m_rvalid_present", 32'(m_rvalid), 1);
        chk("rstw_outputs_zero", 32'({i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, m_be}), 0);
        chk("rstw_m_addr_zero", m_addr, 0);
        chk("rstw_i_rdata_zero", i_rdata, 0);
        chk("rstw_state_idle", 32'(dut.state_q), 32'(IDLE));
      end
    end
    chk("rstw_no_rvalid", rv, 0);
    do_txn(vecs[0], 9);

    // Simultaneous requests: data first, fetch in the ISSUE after data's RESP.
    lat = 1;
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h48;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h100;
    gd = -1; gi = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (d_gnt === 1'b1) begin if (gd < 0) gd = k; d_req = 0; end
      if (i_gnt === 1'b1) begin if (gi < 0) gi = k; i_req = 0; end
    end
    chk("simul_d_gnt_cycle", gd, 1);
    chk("simul_i_gnt_cycle", gi, 4);

    // Starvation: fetch held, data continuously requesting.
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h4C;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h104;
    nd = 0; nd_at = -1; gi_seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (d_gnt === 1'b1) begin
        nd++;
        if (nd == SL) chk("starve_cnt_at_limit", 32'(dut.u_starve.cnt_q), SL);
      end
      if (i_gnt === 1'b1 && !gi_seen) begin
        gi_seen = 1; nd_at = nd; i_req = 0; d_req = 0;
      end
    end
    chk("starve_i_gnt_seen", 32'(gi_seen), 1);
    chk("starve_d_wins_before_i", nd_at, SL);
    chk("starve_d_wins_total", nd, SL);
    chk("starve_cnt_cleared", 32'(dut.u_starve.cnt_q), 0);

    // Back-to-back fetches at latency 3.
    lat = 3;
    @(posedge clk); #1; i_req = 1; i_addr = 32'h0;
    r1 = -1; r2 = -1; ng = 0; d1 = '0; d2 = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (i_gnt === 1'b1) begin
        ng++;
        if (ng == 1) i_addr = 32'h4; else i_req = 0;
      end
      if (i_rvalid === 1'b1) begin
        if (r1 < 0) begin r1 = k; d1 = i_rdata; end
        else begin r2 = k; d2 = i_rdata; end
      end
    end
    chk("b2b_rvalid1_cycle", r1, 5);
    chk("b2b_rvalid2_cycle", r2, 10);
    chk("b2b_rdata1", d1, 32'h00000013);
    chk("b2b_rdata2", d2, 32'h00100093);

    // Randomized traffic against a transaction-level reference.
    rs = 0; ngr = 0;
    exp_drd = ref_rd(32'h104);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (cyc % 100 == 0) lat = $urandom_range(1, 3);
      if ((i_gnt | d_gnt) === 1'b1) begin
        ngr++;
        chk("rnd_gnt_had_req", 32'(i_req | d_req), 1);
        exp_i = i_req && (!d_req || rs == SL);
        chk("rnd_winner", 32'({i_gnt, d_gnt}), exp_i ? 2 : 1);
        if (i_req && d_req && !exp_i) rs = (rs < SL) ? rs + 1 : SL;
        else rs = 0;
        if (i_gnt === 1'b1) begin iq.push_back(i_addr); i_req = 0; end
        if (d_gnt === 1'b1) begin
          t.we = d_we; t.be = d_be; t.addr = d_addr; t.wdata = d_wdata;
          dq.push_back(t); d_req = 0;
        end
      end
      if (i_rvalid === 1'b1) begin
        chk("rnd_i_rvalid_pending", 32'(iq.size()), 1);
        if (iq.size() > 0) chk("rnd_i_rdata", i_rdata, ref_rd(iq.pop_front()));
      end
      if (d_rvalid === 1'b1) begin
        chk("rnd_d_rvalid_pending", 32'(dq.size()), 1);
        if (dq.size() > 0) begin
          t = dq.pop_front();
          if (t.we) ref_mem[t.addr[31:2]] = merge(ref_rd(t.addr), t.be, t.wdata);
          else exp_drd = ref_rd(t.addr);
          chk(t.we ? "rnd_d_wack_rdata" : "rnd_d_rdata", d_rdata, exp_drd);
        end
      end
      if (cyc < 1400) begin
        if (!i_req && $urandom_range(0, 3) == 0) begin
          i_req = 1; i_addr = 32'($urandom_range(0, 15)) << 2;
        end
        if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(1, 15));
          d_addr = 32'($urandom_range(0, 15)) << 2; d_wdata = $urandom;
        end
      end
    end
    chk("rnd_i_drained", 32'(iq.size()), 0);
    chk("rnd_d_drained", 32'(dq.size()), 0);
    chk("rnd_activity", 32'(ngr > 100), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
